id_stage_pipe: RTL and testbench

Parametrised instruction-decode stage for the 5-stage MIPS pipeline. It splits the fetched instruction into fields, reads two operands from an internal register file written by writeback, and extends the immediate by opcode class. All results go into one ID/EX pipeline register with valid, stall and flush control. It sits between the IF/ID register and the execute stage.

---
 rtl/id_stage_pipe.sv | 175 +++++++++++++++++
 tb/tb_id_stage_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe
//   Instruction-decode stage for a 5-stage MIPS pipeline. It splits the
//   fetched instruction into fields, reads rs/rt from an internal register
//   file written by writeback, and extends the immediate by opcode class.
//   All results land in a single ID/EX register with valid/stall/flush control.
//
// Optional feature macro: ID_BYPASS_EN
//   defined   : same-cycle writeback is forwarded into the captured operands,
//               and a writeback that matches a held (stalled) entry refreshes
//               its operand.
//   undefined : reads return the pre-write value; held operands never change.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid              current_inst is a real instruction
//   current_inst[31:0]    instruction from IF/ID
//   stall, flush          hold / squash the ID/EX register (flush wins)
//   we, wb_addr, wb_data  register-file write port (writeback)
//   out_valid             ID/EX entry valid
//   out_opcode/rs/rt/rd/funct/shamt   decoded fields
//   output_data_1/2       rs / rt operands
//   ex_data               extended immediate

module id_stage_pipe #(
    parameter int REG_NUM  = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       current_inst,
    input  logic              stall,
    input  logic              flush,
    input  logic              we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [31:0]       wb_data,
    output logic              out_valid,
    output logic [5:0]        out_opcode,
    output logic [ADDR_W-1:0] out_rs,
    output logic [ADDR_W-1:0] out_rt,
    output logic [ADDR_W-1:0] out_rd,
    output logic [5:0]        out_funct,
    output logic [4:0]        out_shamt,
    output logic [31:0]       output_data_1,
    output logic [31:0]       output_data_2,
    output logic [31:0]       ex_data
);

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    typedef struct packed {
        logic              valid;
        logic [5:0]        opcode;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] rd;
        logic [5:0]        funct;
        logic [4:0]        shamt;
        logic [31:0]       d1;
        logic [31:0]       d2;
        logic [31:0]       ex;
    } idex_t;

    // ------------------------------------------------------------------
    // Field split (register fields use the low ADDR_W bits of each slot)
    // ------------------------------------------------------------------
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] rs_a;
    logic [ADDR_W-1:0] rt_a;
    logic [ADDR_W-1:0] rd_a;

    assign opcode = current_inst[31:26];
    assign rs_a   = current_inst[21 +: ADDR_W];
    assign rt_a   = current_inst[16 +: ADDR_W];
    assign rd_a   = current_inst[11 +: ADDR_W];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] rf [REG_NUM];
    logic        wr_hit;

    // A write to a hardwired-zero r0 is dropped here, so every consumer
    // (array, write-through, stall refresh) sees the same qualified enable.
    assign wr_hit = we && !((ZERO_REG != 0) && (wb_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
        end else if (wr_hit) begin
            rf[wb_addr] <= wb_data;
        end
    end

    logic [31:0] op_1;
    logic [31:0] op_2;

`ifdef ID_BYPASS_EN
    assign op_1 = (wr_hit && (wb_addr == rs_a)) ? wb_data : rf[rs_a];
    assign op_2 = (wr_hit && (wb_addr == rt_a)) ? wb_data : rf[rt_a];
`else
    assign op_1 = rf[rs_a];
    assign op_2 = rf[rt_a];
`endif

    // ------------------------------------------------------------------
    // Immediate extender
    // ------------------------------------------------------------------
    logic [31:0] ext;

    always_comb begin
        ext = {{16{current_inst[15]}}, current_inst[15:0]};
        case (opcode)
            OP_J, OP_JAL:             ext = {6'h0, current_inst[25:0]};
            OP_ANDI, OP_ORI, OP_XORI: ext = {16'h0, current_inst[15:0]};
            OP_LUI:                   ext = {current_inst[15:0], 16'h0};
            default:                  ;
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX register: flush > stall > load
    // ------------------------------------------------------------------
    idex_t nxt;
    idex_t q;

    always_comb begin
        nxt        = '0;
        nxt.valid  = in_valid;
        nxt.opcode = opcode;
        nxt.rs     = rs_a;
        nxt.rt     = rt_a;
        nxt.rd     = rd_a;
        nxt.funct  = current_inst[5:0];
        nxt.shamt  = current_inst[10:6];
        nxt.d1     = op_1;
        nxt.d2     = op_2;
        nxt.ex     = ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (stall) begin
`ifdef ID_BYPASS_EN
            // Keep a held entry coherent with writeback so it never
            // leaves the stall carrying a stale operand.
            if (wr_hit && (wb_addr == q.rs)) q.d1 <= wb_data;
            if (wr_hit && (wb_addr == q.rt)) q.d2 <= wb_data;
`endif
        end else begin
            q <= nxt;
        end
    end

    assign out_valid     = q.valid;
    assign out_opcode    = q.opcode;
    assign out_rs        = q.rs;
    assign out_rt        = q.rt;
    assign out_rd        = q.rd;
    assign out_funct     = q.funct;
    assign out_shamt     = q.shamt;
    assign output_data_1 = q.d1;
    assign output_data_2 = q.d2;
    assign ex_data       = q.ex;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe
//   Scoreboard bench for id_stage_pipe: the driver pushes the hand-computed
//   expected ID/EX contents for every cycle it drives, and a monitor pops
//   and compares one entry after each rising edge.
module tb_id_stage_pipe;

`ifdef ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] ex;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] current_inst;
    logic        stall;
    logic        flush;
    logic        we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [5:0]  out_funct;
    logic [4:0]  out_shamt;
    logic [31:0] output_data_1;
    logic [31:0] output_data_2;
    logic [31:0] ex_data;

    id_stage_pipe #(.REG_NUM(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .current_inst(current_inst),
        .stall(stall), .flush(flush), .we(we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_rs(out_rs),
        .out_rt(out_rt), .out_rd(out_rd), .out_funct(out_funct),
        .out_shamt(out_shamt), .output_data_1(output_data_1),
        .output_data_2(output_data_2), .ex_data(ex_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    vectors    = 0;
    int    miscompares = 0;
    exp_t  exp_q[$];
    string name_q[$];

    // Expected entry: fields are plain bit slices of the instruction word;
    // operands and immediate are supplied by hand.
    function automatic exp_t mk(input bit v, input logic [31:0] inst,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] ex);
        exp_t e;
        e.v  = v;
        e.op = inst[31:26];
        e.rs = inst[25:21];
        e.rt = inst[20:16];
        e.rd = inst[15:11];
        e.fn = inst[5:0];
        e.sh = inst[10:6];
        e.d1 = d1;
        e.d2 = d2;
        e.ex = ex;
        return e;
    endfunction

    function automatic exp_t act();
        return {out_valid, out_opcode, out_rs, out_rt, out_rd, out_funct,
                out_shamt, output_data_1, output_data_2, ex_data};
    endfunction

    task automatic compare(input string name, input exp_t a, input exp_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got v=%0b op=%h rs=%0d rt=%0d rd=%0d fn=%h sh=%0d d1=%h d2=%h ex=%h, required v=%0b op=%h rs=%0d rt=%0d rd=%0d fn=%h sh=%0d d1=%h d2=%h ex=%h",
                     name, a.v, a.op, a.rs, a.rt, a.rd, a.fn, a.sh, a.d1, a.d2, a.ex,
                     e.v, e.op, e.rs, e.rt, e.rd, e.fn, e.sh, e.d1, e.d2, e.ex);
        end
    endtask

    // Monitor: one expected entry per driven cycle, checked just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) compare(name_q.pop_front(), act(), exp_q.pop_front());
        end
    end

    task automatic cyc(input string name, input logic iv, input logic [31:0] inst,
                       input logic st, input logic fl, input logic w,
                       input logic [4:0] wa, input logic [31:0] wd, input exp_t e);
        @(negedge clk);
        in_valid     = iv;
        current_inst = inst;
        stall        = st;
        flush        = fl;
        we           = w;
        wb_addr      = wa;
        wb_data      = wd;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    localparam logic [31:0] I_LW   = 32'h8C22FFFC; // lw   r2, -4(r1)
    localparam logic [31:0] I_ORI  = 32'h34648000; // ori  r4, r3, 0x8000
    localparam logic [31:0] I_LUI  = 32'h3C06ABCD; // lui  r6, 0xABCD
    localparam logic [31:0] I_J    = 32'h0BFFFFFF; // j    0x3FFFFFF
    localparam logic [31:0] I_ANDI = 32'h30A5FFFF; // andi r5, r5, 0xFFFF
    localparam logic [31:0] I_ADDI = 32'h20000001; // addi r0, r0, 1
    localparam logic [31:0] I_ADD  = 32'h00A33820; // add  r7, r5, r3
    localparam logic [31:0] I_SW   = 32'hAC69FFF0; // sw   r9, -16(r3)

    exp_t held;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; current_inst = '0; stall = 1'b0;
        flush = 1'b0; we = 1'b0; wb_addr = '0; wb_data = '0;
        #12;
        compare("reset", act(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc("lw_sext",   1, I_LW,   0, 0, 0, 5'd0, 32'h0,
            mk(1, I_LW, 32'h0, 32'h0, 32'hFFFFFFFC));
        cyc("wr_r3",     0, 32'h0,  0, 0, 1, 5'd3, 32'h12345678, '0);
        cyc("ori_zext",  1, I_ORI,  0, 0, 0, 5'd0, 32'h0,
            mk(1, I_ORI, 32'h12345678, 32'h0, 32'h00008000));
        cyc("lui",       1, I_LUI,  0, 0, 0, 5'd0, 32'h0,
            mk(1, I_LUI, 32'h0, 32'h0, 32'hABCD0000));
        cyc("j_target",  1, I_J,    0, 0, 0, 5'd0, 32'h0,
            mk(1, I_J, 32'h0, 32'h0, 32'h03FFFFFF));
        cyc("andi_zext", 1, I_ANDI, 0, 0, 0, 5'd0, 32'h0,
            mk(1, I_ANDI, 32'h0, 32'h0, 32'h0000FFFF));
        // r0 write in the same cycle as an r0 read: hardwired zero in both modes
        cyc("r0_wr_rd",  1, I_ADDI, 0, 0, 1, 5'd0, 32'hFFFFFFFF,
            mk(1, I_ADDI, 32'h0, 32'h0, 32'h00000001));
        cyc("wr_r5",     0, 32'h0,  0, 0, 1, 5'd5, 32'h11111111, '0);
        cyc("r0_after",  1, I_ADDI, 0, 0, 0, 5'd0, 32'h0,
            mk(1, I_ADDI, 32'h0, 32'h0, 32'h00000001));
        cyc("same_cyc",  1, I_ADD,  0, 0, 1, 5'd5, 32'hCAFEF00D,
            mk(1, I_ADD, BYP ? 32'hCAFEF00D : 32'h11111111, 32'h12345678, 32'h00003820));

        held = mk(1, I_SW, 32'h12345678, 32'h0, 32'hFFFFFFF0);
        cyc("sw_load",   1, I_SW,   0, 0, 0, 5'd0, 32'h0, held);
        cyc("stall_1",   1, I_LUI,  1, 0, 0, 5'd0, 32'h0, held);
        if (BYP) held.d2 = 32'hDEADBEEF;
        cyc("stall_wr",  1, I_LUI,  1, 0, 1, 5'd9, 32'hDEADBEEF, held);
        cyc("unstall",   1, I_LUI,  0, 0, 0, 5'd0, 32'h0,
            mk(1, I_LUI, 32'h0, 32'h0, 32'hABCD0000));
        cyc("stall_flush", 1, I_ORI, 1, 1, 0, 5'd0, 32'h0, '0);
        cyc("reload",    1, I_ORI,  0, 0, 0, 5'd0, 32'h0,
            mk(1, I_ORI, 32'h12345678, 32'h0, 32'h00008000));

        // Asynchronous reset mid-cycle while a valid entry is held
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compare("async_rst", act(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rf_cleared", 1, I_ORI, 0, 0, 0, 5'd0, 32'h0,
            mk(1, I_ORI, 32'h0, 32'h0, 32'h00008000));

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
